// File: rtl/add_out_pkg_hdl.sv
// Shared types and default constants for the add_out responder.
package add_out_pkg_hdl;

    localparam int ADD_WIDTH_DEFAULT      = 4;
    localparam int FIFO_DEPTH_DEFAULT     = 4;
    localparam int RESULT_LATENCY_DEFAULT = 1;

    // Wide enough for the largest supported latency load value (6).
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        REPORT
    } add_out_resp_state_t;

endpackage

// File: rtl/add_out_op_fifo.sv
// Synchronous operand-pair FIFO with a registered occupancy count.
module add_out_op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count only, so a full FIFO never takes a push
    // in the same cycle it is popped.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/add_out_responder.sv
// Buffers operand pairs, drives them to an external adder, samples the
// result after a fixed latency and reports it with a correctness flag.
module add_out_responder
    import add_out_pkg_hdl::*;
#(
    parameter int ADD_WIDTH      = ADD_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int RESULT_LATENCY = RESULT_LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [ADD_WIDTH-1:0] op_a,
    input  logic [ADD_WIDTH-1:0] op_b,
    output logic [ADD_WIDTH-1:0] a,
    output logic [ADD_WIDTH-1:0] b,
    input  logic [ADD_WIDTH-1:0] sum_in,
    input  logic                 cout_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ADD_WIDTH:0]   res_sum,
    output logic                 res_mismatch,
    output logic                 busy
);

    localparam int PAIR_W = 2 * ADD_WIDTH;

    add_out_resp_state_t    state;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [PAIR_W-1:0]      head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [ADD_WIDTH:0]     sampled;
    logic [ADD_WIDTH:0]     expected;

    assign op_ready = !fifo_full;
    assign pop      = (state == IDLE) && !fifo_empty;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign sampled  = {cout_in, sum_in};
    assign expected = {1'b0, a} + {1'b0, b};

    add_out_op_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (op_valid),
        .push_data ({op_a, op_b}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pops happen only from IDLE, so a result handshake always costs one idle cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            lat_cnt      <= '0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        {a, b}  <= head;
                        lat_cnt <= LAT_CNT_W'(RESULT_LATENCY - 1);
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (lat_cnt == '0) begin
                        res_sum      <= sampled;
                        res_mismatch <= (sampled != expected);
                        res_valid    <= 1'b1;
                        state        <= REPORT;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_out_responder.sv
// Scoreboard bench for add_out_responder: one latency-1 instance with a
// fault-injectable adder, plus a latency-3 instance for the timing check.
module tb_add_out_responder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic       mis;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       op_valid, op_ready, res_valid, res_ready, res_mismatch, busy, cout_in;
    logic [3:0] op_a, op_b, a, b, sum_in;
    logic [4:0] res_sum;
    logic       force_zero;

    logic       op_valid3, op_ready3, res_valid3, res_ready3, res_mismatch3, busy3, cout_in3;
    logic [3:0] op_a3, op_b3, a3, b3, sum_in3;
    logic [4:0] res_sum3;

    exp_t q[$];
    int   tests_run;
    int   tests_failed;
    logic seen;

    add_out_responder #(
        .ADD_WIDTH      (4),
        .FIFO_DEPTH     (4),
        .RESULT_LATENCY (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .a            (a),
        .b            (b),
        .sum_in       (sum_in),
        .cout_in      (cout_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_mismatch (res_mismatch),
        .busy         (busy)
    );

    add_out_responder #(
        .ADD_WIDTH      (4),
        .FIFO_DEPTH     (4),
        .RESULT_LATENCY (3)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid3),
        .op_ready     (op_ready3),
        .op_a         (op_a3),
        .op_b         (op_b3),
        .a            (a3),
        .b            (b3),
        .sum_in       (sum_in3),
        .cout_in      (cout_in3),
        .res_valid    (res_valid3),
        .res_ready    (res_ready3),
        .res_sum      (res_sum3),
        .res_mismatch (res_mismatch3),
        .busy         (busy3)
    );

    // Adder models; the first can be forced to a wrong (zero) result.
    assign {cout_in, sum_in}   = force_zero ? 5'd0 : ({1'b0, a} + {1'b0, b});
    assign {cout_in3, sum_in3} = {1'b0, a3} + {1'b0, b3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each new result of the main instance is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            seen = 1'b0;
        end else if (res_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            tests_run++;
            if (q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_result got res_sum=%b a=%0d b=%0d, expected none", res_sum, a, b);
            end else begin
                e = q.pop_front();
                if (res_sum !== e.sum || res_mismatch !== e.mis || a !== e.a || b !== e.b) begin
                    tests_failed++;
                    $display("[TB] FAIL result got a=%0d b=%0d sum=%b mis=%b, expected a=%0d b=%0d sum=%b mis=%b",
                             a, b, res_sum, res_mismatch, e.a, e.b, e.sum, e.mis);
                end
            end
        end else if (res_valid !== 1'b1) begin
            seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl got op_ready=%b busy=%b res_valid=%b, expected 1 0 0", op_ready, busy, res_valid);
        end
        tests_run++;
        if (a !== 4'd0 || b !== 4'd0 || res_sum !== 5'd0 || res_mismatch !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got a=%0d b=%0d sum=%b mis=%b, expected zeros", a, b, res_sum, res_mismatch);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        op_valid = 1'b1; op_a = 4'd7; op_b = 4'd9;
        q.push_back('{4'd7, 4'd9, 5'b10000, 1'b0});
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a !== 4'd7 || b !== 4'd9 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_drive got a=%0d b=%0d res_valid=%b, expected 7 9 0", a, b, res_valid);
        end
        @(negedge clk);
        tests_run++;
        if (res_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency got res_valid=%b at +3, expected 1", res_valid);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_handshake got res_valid=%b busy=%b, expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_carry();
        int n;
        @(negedge clk);
        op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        q.push_back('{4'd15, 4'd15, 5'b11110, 1'b0});
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (res_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL carry_timeout got res_valid=%b, expected 1", res_valid);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_mismatch();
        int n;
        force_zero = 1'b1;
        @(negedge clk);
        op_valid = 1'b1; op_a = 4'd3; op_b = 4'd4;
        q.push_back('{4'd3, 4'd4, 5'b00000, 1'b1});
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (res_valid !== 1'b1 || res_mismatch !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_flag got res_valid=%b mis=%b, expected 1 1", res_valid, res_mismatch);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        force_zero = 1'b0;
    endtask

    task automatic test_backpressure();
        logic       exp_ready;
        logic [3:0] va, vb;
        logic [4:0] es;
        int         n;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            va = 4'($urandom_range(0, 15));
            vb = 4'($urandom_range(0, 15));
            es = {1'b0, va} + {1'b0, vb};
            exp_ready = (i < 5);
            tests_run++;
            if (op_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL bp_ready_%0d got op_ready=%b, expected %b", i, op_ready, exp_ready);
            end
            op_valid = 1'b1; op_a = va; op_b = vb;
            if (exp_ready) q.push_back('{va, vb, es, 1'b0});
        end
        @(negedge clk);
        op_valid = 1'b0;
        tests_run++;
        if (op_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_full got op_ready=%b, expected 0", op_ready);
        end
        res_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (q.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain got %0d pending busy=%b, expected 0 pending busy=0", q.size(), busy);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic any_valid;
        @(negedge clk);
        op_valid = 1'b1; op_a = 4'd5; op_b = 4'd6;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || a !== 4'd5 || b !== 4'd6) begin
            tests_failed++;
            $display("[TB] FAIL abort_drive got busy=%b a=%0d b=%0d, expected 1 5 6", busy, a, b);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a !== 4'd0 || b !== 4'd0 || res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_state got a=%0d b=%0d res_valid=%b busy=%b op_ready=%b, expected 0 0 0 0 1",
                     a, b, res_valid, busy, op_ready);
        end
        rst = 1'b1;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid === 1'b1) any_valid = 1'b1;
        end
        tests_run++;
        if (any_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_result got res_valid seen=%b, expected 0", any_valid);
        end
    endtask

    task automatic test_latency3();
        @(negedge clk);
        tests_run++;
        if (op_ready3 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL l3_ready got op_ready=%b, expected 1", op_ready3);
        end
        op_valid3 = 1'b1; op_a3 = 4'd1; op_b3 = 4'd2;
        @(negedge clk);
        op_valid3 = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (a3 !== 4'd1 || b3 !== 4'd2 || res_valid3 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL l3_hold_%0d got a=%0d b=%0d res_valid=%b, expected 1 2 0", k, a3, b3, res_valid3);
            end
        end
        @(negedge clk);
        tests_run++;
        if (res_valid3 !== 1'b1 || res_sum3 !== 5'b00011 || res_mismatch3 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL l3_result got res_valid=%b sum=%b mis=%b, expected 1 00011 0",
                     res_valid3, res_sum3, res_mismatch3);
        end
        res_ready3 = 1'b1;
        @(negedge clk);
        res_ready3 = 1'b0;
        tests_run++;
        if (busy3 !== 1'b0 || res_valid3 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL l3_done got busy=%b res_valid=%b, expected 0 0", busy3, res_valid3);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        seen         = 1'b0;
        rst          = 1'b0;
        force_zero   = 1'b0;
        op_valid     = 1'b0; op_a  = '0; op_b  = '0; res_ready  = 1'b0;
        op_valid3    = 1'b0; op_a3 = '0; op_b3 = '0; res_ready3 = 1'b0;

        test_reset();
        test_basic();
        test_carry();
        test_mismatch();
        test_backpressure();
        test_abort();
        test_latency3();

        @(negedge clk);
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL leftover got %0d unreported results, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
